// File: rtl/spi_write_sequencer_if.sv
// Register-write request channel between two on-chip requesters and the SPI write sequencer.
// The master side is the requester pair; the slave side is the sequencer.
interface spi_write_sequencer_if;
  logic       req0_valid;
  logic [6:0] req0_addr;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [6:0] req1_addr;
  logic [7:0] req1_data;
  logic       req1_ready;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/spi_write_sequencer.sv
// Round-robin arbiter plus mode-0 SPI serializer: each accepted request becomes one
// 16-bit frame {1, addr, data}, paced slowly for a peripheral that oversamples the pins.
module spi_write_sequencer #(
  parameter int HALF_PERIOD = 50,
  parameter int CS_SETUP    = 50,
  parameter int CS_HOLD     = 50,
  parameter int IDLE_GAP    = 100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_write_sequencer_if.slave  req,
  output logic                  busy,
  output logic                  done,
  output logic                  done_id,
  output logic                  ncs,
  output logic                  sclk,
  output logic                  copi
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HALF_LD  = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(IDLE_GAP - 1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_idx;
  logic             ptr;
  logic             cur_id;
  logic             gnt_id;
  logic             accept;
  logic [14:0]      word;

  // Pointer only matters when both requesters contend; a lone requester always wins.
  always_comb begin
    gnt_id = req.req1_valid;
    if (req.req0_valid && req.req1_valid) gnt_id = ptr;
  end

  assign accept         = rst_n && (state == IDLE) && (req.req0_valid || req.req1_valid);
  assign req.req0_ready = rst_n && (state == IDLE) && req.req0_valid && !gnt_id;
  assign req.req1_ready = rst_n && (state == IDLE) && req.req1_valid &&  gnt_id;

  // The write flag (bit 15) is constant, so only {addr, data} is stored.
  always_ff @(posedge clk) begin
    if (accept) word <= gnt_id ? {req.req1_addr, req.req1_data} : {req.req0_addr, req.req0_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      ptr     <= 1'b0;
      cur_id  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      ncs     <= 1'b1;
      sclk    <= 1'b0;
      copi    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cur_id <= gnt_id;
            ptr    <= !gnt_id;
            busy   <= 1'b1;
            ncs    <= 1'b0;
            copi   <= 1'b1;
            cnt    <= SETUP_LD;
            state  <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            sclk    <= 1'b1;
            bit_idx <= '0;
            cnt     <= HALF_LD;
            state   <= HIGH;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HIGH: begin
          if (cnt == '0) begin
            sclk <= 1'b0;
            if (bit_idx == 4'd15) begin
              cnt   <= HOLD_LD;
              state <= HOLD;
            end else begin
              // Next bit is launched on the falling edge so it is stable for the whole high phase.
              copi    <= word[4'd14 - bit_idx];
              bit_idx <= bit_idx + 1'b1;
              cnt     <= HALF_LD;
              state   <= LOW;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        LOW: begin
          if (cnt == '0) begin
            sclk  <= 1'b1;
            cnt   <= HALF_LD;
            state <= HIGH;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            ncs     <= 1'b1;
            done    <= 1'b1;
            done_id <= cur_id;
            cnt     <= GAP_LD;
            state   <= GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
